// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module : pipe_pkg
// Brief  : Shared encodings for the pipeline hazard controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_fwd_unit.sv
//------------------------------------------------------------------------------
// Module : pipe_fwd_unit
// Brief  : Combinational EX-stage operand forwarding select.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic       i_mem_regw,
    input  logic [4:0] i_mem_wbdst,
    input  logic       i_wb_regw,
    input  logic [4:0] i_wb_wbdst,
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_ex_rt,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    // The younger producer (EX/MEM) holds the newest value and wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       mem_regw,
                                           input logic [4:0] mem_dst,
                                           input logic       wb_regw,
                                           input logic [4:0] wb_dst);
        if (mem_regw && reg_match(mem_dst, src)) begin
            return FWD_MEM;
        end else if (wb_regw && reg_match(wb_dst, src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        o_fwd_a = fwd_sel(i_ex_rs, i_mem_regw, i_mem_wbdst, i_wb_regw, i_wb_wbdst);
        o_fwd_b = fwd_sel(i_ex_rt, i_mem_regw, i_mem_wbdst, i_wb_regw, i_wb_wbdst);
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module : pipe_hazard_ctrl
// Brief  : 5-stage pipeline register sequencing: stalls, flushes, forwarding.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_wbdst,
    input  logic             i_mem_regw,
    input  logic [4:0]       i_mem_wbdst,
    input  logic             i_wb_regw,
    input  logic [4:0]       i_wb_wbdst,
    input  logic [4:0]       i_ex_rs,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_br_taken,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_memwb_bubble,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int               WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_mem_err;
    logic [CNT_W-1:0]   r_stall_cnt;

    state_t             w_state_nxt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic               w_err_set;
    logic               w_pc_en;
    logic               w_ifid_en;
    logic               w_idex_en;
    logic               w_exmem_en;
    logic               w_memwb_en;
    logic               w_ifid_flush;
    logic               w_idex_flush;
    logic               w_bubble;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;

    logic w_load_use;
    logic w_mem_miss;
    logic w_wait_done;

    assign w_load_use  = i_ex_memread &&
                         (reg_match(i_ex_wbdst, i_id_rs) || reg_match(i_ex_wbdst, i_id_rt));
    assign w_mem_miss  = i_dmem_req && !i_dmem_ack;
    assign w_wait_done = i_dmem_ack || (r_wait_cnt == WAIT_LAST);

    pipe_fwd_unit u_fwd (
        .i_mem_regw  (i_mem_regw),
        .i_mem_wbdst (i_mem_wbdst),
        .i_wb_regw   (i_wb_regw),
        .i_wb_wbdst  (i_wb_wbdst),
        .i_ex_rs     (i_ex_rs),
        .i_ex_rt     (i_ex_rt),
        .o_fwd_a     (w_fwd_a),
        .o_fwd_b     (w_fwd_b)
    );

    always_comb begin
        w_state_nxt  = ST_RUN;
        w_wait_nxt   = '0;
        w_err_set    = 1'b0;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_idex_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_bubble     = 1'b0;

        case (r_state)
            ST_RUN, ST_LU_STALL: begin
                if (w_mem_miss) begin
                    w_pc_en     = 1'b0;
                    w_ifid_en   = 1'b0;
                    w_idex_en   = 1'b0;
                    w_exmem_en  = 1'b0;
                    w_bubble    = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                end else if (r_state == ST_RUN && w_load_use) begin
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_idex_flush = 1'b1;
                    w_state_nxt  = ST_LU_STALL;
                end else if (r_state == ST_RUN && i_br_taken) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // A timeout releases the pipe exactly like an ack; the loaded data is garbage.
                if (w_wait_done) begin
                    w_err_set = !i_dmem_ack;
                end else begin
                    w_pc_en     = 1'b0;
                    w_ifid_en   = 1'b0;
                    w_idex_en   = 1'b0;
                    w_exmem_en  = 1'b0;
                    w_bubble    = 1'b1;
                    w_wait_nxt  = r_wait_cnt + 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
            if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Reset must force safe values in the same cycle, so it gates the decode directly.
    assign o_pc_en        = !rst && w_pc_en;
    assign o_ifid_en      = !rst && w_ifid_en;
    assign o_idex_en      = !rst && w_idex_en;
    assign o_exmem_en     = !rst && w_exmem_en;
    assign o_memwb_en     = !rst && w_memwb_en;
    assign o_ifid_flush   = !rst && w_ifid_flush;
    assign o_idex_flush   = !rst && w_idex_flush;
    assign o_memwb_bubble = rst || w_bubble;
    assign o_fwd_a        = rst ? FWD_RF : w_fwd_a;
    assign o_fwd_b        = rst ? FWD_RF : w_fwd_b;
    assign o_mem_err      = r_mem_err;
    assign o_stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_pipe_hazard_ctrl
// Brief  : Scoreboard bench for pipe_hazard_ctrl with a behavioural model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int TO   = 16;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          pc;
        logic          ifid;
        logic          idex;
        logic          exmem;
        logic          memwb;
        logic          ifl;
        logic          idfl;
        logic          bub;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_wbdst, mem_wbdst, wb_wbdst, ex_rs, ex_rt;
    logic ex_memread, mem_regw, wb_regw, br_taken, dmem_req, dmem_ack;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, bubble;
    logic [1:0] fwd_a, fwd_b;
    logic mem_err;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Reference state: whether an access is outstanding, how long it has waited,
    // and whether the previous cycle was a load-use stall.
    bit m_wait;
    int m_waited;
    bit m_lu;
    bit m_err;
    int m_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_memread(ex_memread), .i_ex_wbdst(ex_wbdst),
        .i_mem_regw(mem_regw), .i_mem_wbdst(mem_wbdst), .i_wb_regw(wb_regw), .i_wb_wbdst(wb_wbdst),
        .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_br_taken(br_taken),
        .i_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en), .o_exmem_en(exmem_en),
        .o_memwb_en(memwb_en), .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
        .o_memwb_bubble(bubble), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
        .o_mem_err(mem_err), .o_stall_cnt(stall_cnt)
    );

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (mem_regw && mem_wbdst != 0 && mem_wbdst == src) return 2'b10;
        if (wb_regw && wb_wbdst != 0 && wb_wbdst == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic freeze(inout exp_t e);
        e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwb = 1; e.bub = 1;
    endtask

    // Predict this cycle's outputs from the current inputs, then advance the model.
    task automatic commit();
        exp_t e;
        bit   lu;
        e = '0;
        if (rst) begin
            e.bub = 1;
            m_wait = 0; m_waited = 0; m_lu = 0; m_err = 0; m_cnt = 0;
            q.push_back(e);
            return;
        end
        e.fa = ref_fwd(ex_rs);
        e.fb = ref_fwd(ex_rt);
        {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b11111;
        e.err = m_err;
        e.cnt = CW'(m_cnt);
        lu = ex_memread && ex_wbdst != 0 && (ex_wbdst == id_rs || ex_wbdst == id_rt);
        if (m_wait) begin
            if (dmem_ack || m_waited == TO - 1) begin
                if (!dmem_ack) m_err = 1;
                m_wait = 0;
                m_waited = 0;
            end else begin
                freeze(e);
                m_waited++;
            end
        end else if (dmem_req && !dmem_ack) begin
            freeze(e);
            m_wait = 1;
            m_waited = 0;
            m_lu = 0;
        end else if (m_lu) begin
            m_lu = 0;
        end else if (lu) begin
            e.pc = 0; e.ifid = 0; e.idfl = 1;
            m_lu = 1;
        end else if (br_taken) begin
            e.ifl = 1; e.idfl = 1;
        end
        q.push_back(e);
        if (!e.pc && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_memread = 0; ex_wbdst = 0; mem_regw = 0; mem_wbdst = 0;
        wb_regw = 0; wb_wbdst = 0; ex_rs = 0; ex_rt = 0; br_taken = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic step();
        commit();
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh set of outputs.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                     bubble, fwd_a, fwd_b, mem_err, stall_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle t=%0t actual=%h required=%h", $time, a, e);
                end
            end
        end
    end

    initial begin
        rst = 1;
        idle();
        @(negedge clk);
        step(); step();
        rst = 0;
        step();

        // load-use on $2, then its release cycle
        ex_memread = 1; ex_wbdst = 2; id_rs = 2; step();
        step();
        idle(); step();
        // load into $0 never stalls
        ex_memread = 1; ex_wbdst = 0; id_rs = 0; step();
        idle();
        // forwarding priority then fallback
        mem_regw = 1; mem_wbdst = 5; wb_regw = 1; wb_wbdst = 5; ex_rs = 5; ex_rt = 5; step();
        mem_regw = 0; step();
        br_taken = 1; idle(); br_taken = 1; step();
        idle(); step();

        // 3-cycle memory wait from a clean counter
        rst = 1; step();
        rst = 0; step();
        dmem_req = 1; step(); step(); step();
        dmem_ack = 1; step();
        idle(); step();
        #3;
        check_val("stall_cnt_after_ack", int'(stall_cnt), 3);
        check_val("mem_err_after_ack", int'(mem_err), 0);
        @(negedge clk);

        // timeout
        rst = 1; step();
        rst = 0; step();
        dmem_req = 1;
        for (int i = 0; i < TO + 1; i++) step();
        idle(); step(); step(); step();
        #3;
        check_val("mem_err_sticky", int'(mem_err), 1);
        check_val("stall_cnt_timeout", int'(stall_cnt), TO);
        @(negedge clk);

        // reset in the middle of a memory wait
        dmem_req = 1; step(); step();
        rst = 1; step();
        #3;
        check_val("mem_err_reset", int'(mem_err), 0);
        check_val("memwb_bubble_reset", int'(bubble), 1);
        @(negedge clk);
        rst = 0; step(); step();
        idle(); step();

        // randomized traffic; occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_wbdst   = 5'($urandom_range(0, 3));
            mem_regw   = 1'($urandom_range(0, 1));
            mem_wbdst  = 5'($urandom_range(0, 3));
            wb_regw    = 1'($urandom_range(0, 1));
            wb_wbdst   = 5'($urandom_range(0, 3));
            ex_rs      = 5'($urandom_range(0, 3));
            ex_rt      = 5'($urandom_range(0, 3));
            br_taken   = ($urandom_range(0, 4) == 0);
            if (m_wait) begin
                dmem_req = 1;
                dmem_ack = ($urandom_range(0, 7) == 0);
            end else if (m_lu) begin
                dmem_req = 0;
                dmem_ack = 0;
            end else begin
                dmem_req = ($urandom_range(0, 5) == 0);
                dmem_ack = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        rst = 0;
        idle(); step();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #3;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
